// File: rtl/serial_magnitude_compare_ctrl.sv
// Serial magnitude comparator controller.
// Compares two WIDTH-bit unsigned operands with one 2-bit compare slice,
// walking one digit per cycle from the most significant digit down.
// Valid/ready handshake on both sides, one transaction in flight at a time.
module serial_magnitude_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_greater,
  output logic             b_greater,
  output logic             equal,
  output logic             busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDX_W-1:0] idx;
  // Sticky record of the first (most significant) inequality seen so far.
  logic             rec_a;
  logic             rec_b;

  logic [1:0]       dig_a;
  logic [1:0]       dig_b;
  logic             dig_gt;
  logic             dig_lt;
  logic             nxt_a;
  logic             nxt_b;

  // Extract digit d (bits [2d+1:2d]) of an operand.
  function automatic logic [1:0] digit_at(input logic [WIDTH-1:0] v,
                                          input logic [IDX_W-1:0] d);
    logic [WIDTH-1:0] sh;
    sh = v >> {d, 1'b0};
    return sh[1:0];
  endfunction

  // Current digit compare and the sticky result it would produce; an earlier
  // inequality always wins over later digits.
  always_comb begin
    dig_a  = digit_at(op_a, idx);
    dig_b  = digit_at(op_b, idx);
    dig_gt = (dig_a > dig_b);
    dig_lt = (dig_a < dig_b);
    nxt_a  = rec_a | (dig_gt & ~rec_b);
    nxt_b  = rec_b | (dig_lt & ~rec_a);
  end

  // Handshake and status outputs decode directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == COMPARE) || (state == DONE);

  // Controller FSM: accept operands, walk digits MSB first, hold the result
  // until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      idx       <= IDX_W'(DIGITS - 1);
      rec_a     <= 1'b0;
      rec_b     <= 1'b0;
      a_greater <= 1'b0;
      b_greater <= 1'b0;
      equal     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            idx   <= IDX_W'(DIGITS - 1);
            rec_a <= 1'b0;
            rec_b <= 1'b0;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          rec_a <= nxt_a;
          rec_b <= nxt_b;
          if (EARLY_EXIT && (dig_gt || dig_lt)) begin
            a_greater <= nxt_a;
            b_greater <= nxt_b;
            equal     <= 1'b0;
            state     <= DONE;
          end else if (idx == '0) begin
            a_greater <= nxt_a;
            b_greater <= nxt_b;
            equal     <= ~nxt_a & ~nxt_b;
            state     <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            a_greater <= 1'b0;
            b_greater <= 1'b0;
            equal     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_compare_ctrl.sv
// Bench for serial_magnitude_compare_ctrl: one early-exit instance (slot 1)
// and one constant-latency instance (slot 0), directed vectors.
module tb_serial_magnitude_compare_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] in_valid;
  logic [1:0] in_ready;
  logic [7:0] in_a [2];
  logic [7:0] in_b [2];
  logic [1:0] out_valid;
  logic [1:0] out_ready;
  logic [1:0] ag;
  logic [1:0] bg;
  logic [1:0] eq;
  logic [1:0] busy;

  int checks;
  int errors;

  serial_magnitude_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .a_greater(ag[0]), .b_greater(bg[0]), .equal(eq[0]), .busy(busy[0])
  );

  serial_magnitude_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .a_greater(ag[1]), .b_greater(bg[1]), .equal(eq[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         s;
    logic [7:0] a;
    logic [7:0] b;
    logic       ag;
    logic       bg;
    logic       eq;
    int         lat;
    string      name;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags as {a_greater, b_greater, equal} for slot s.
  function automatic logic [2:0] flags(input int s);
    return {ag[s], bg[s], eq[s]};
  endfunction

  // Wait (bounded) for out_valid on slot s; returns negedges counted.
  task automatic wait_result(input int s, output int cnt);
    cnt = 0;
    while (!out_valid[s] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // One full transaction with out_ready held high.
  task automatic run_vec(input vec_t v);
    int cnt;
    @(negedge clk);
    chk({v.name, " in_ready idle"}, 32'(in_ready[v.s]), 32'd1);
    in_a[v.s]      = v.a;
    in_b[v.s]      = v.b;
    in_valid[v.s]  = 1'b1;
    out_ready[v.s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[v.s] = 1'b0;
    in_a[v.s]     = 8'h00;
    in_b[v.s]     = 8'h00;
    chk({v.name, " busy after accept"}, 32'({busy[v.s], in_ready[v.s]}), 32'b10);
    chk({v.name, " flags during compare"}, 32'({out_valid[v.s], flags(v.s)}), 32'd0);
    wait_result(v.s, cnt);
    chk({v.name, " latency"}, 32'(cnt), 32'(v.lat));
    chk({v.name, " flags"}, 32'(flags(v.s)), 32'({v.ag, v.bg, v.eq}));
    @(negedge clk);
    chk({v.name, " after handshake"},
        32'({out_valid[v.s], flags(v.s), busy[v.s], in_ready[v.s]}), 32'b0_000_0_1);
  endtask

  initial begin
    int cnt;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    in_a[0] = 8'h00; in_a[1] = 8'h00;
    in_b[0] = 8'h00; in_b[1] = 8'h00;

    //            s  a      b      ag    bg    eq    lat name
    vecs[0]  = '{1, 8'hB4, 8'hB4, 1'b0, 1'b0, 1'b1, 4, "ee_equal_b4"};
    vecs[1]  = '{1, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1, "ee_80_7f"};
    vecs[2]  = '{1, 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 4, "ee_12_13"};
    vecs[3]  = '{1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4, "ee_zero"};
    vecs[4]  = '{1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1, "ee_ff_00"};
    vecs[5]  = '{1, 8'h34, 8'h24, 1'b1, 1'b0, 1'b0, 2, "ee_34_24"};
    vecs[6]  = '{0, 8'hC0, 8'h3F, 1'b1, 1'b0, 1'b0, 4, "cl_c0_3f"};
    vecs[7]  = '{0, 8'h3F, 8'hC0, 1'b0, 1'b1, 1'b0, 4, "cl_3f_c0"};
    vecs[8]  = '{0, 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 4, "cl_12_13"};
    vecs[9]  = '{0, 8'hB4, 8'hB4, 1'b0, 1'b0, 1'b1, 4, "cl_equal_b4"};
    vecs[10] = '{0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 4, "cl_01_00"};

    // Reset state
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset state slot%0d", s),
          32'({out_valid[s], flags(s), busy[s], in_ready[s]}), 32'b0_000_0_1);
    end
    rst = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Stall the result with out_ready low while new operands are offered
    @(negedge clk);
    in_a[1] = 8'h80; in_b[1] = 8'h7F;
    in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    wait_result(1, cnt);
    chk("stall latency", 32'(cnt), 32'd1);
    in_a[1] = 8'h00; in_b[1] = 8'hFF; in_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall hold %0d", k),
          32'({out_valid[1], flags(1), in_ready[1], busy[1]}), 32'b1_100_0_1);
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("stall released idle",
        32'({out_valid[1], flags(1), in_ready[1]}), 32'b0_000_1);
    @(negedge clk);
    in_valid[1] = 1'b0;
    chk("stall new accepted", 32'({busy[1], in_ready[1], out_valid[1]}), 32'b100);
    wait_result(1, cnt);
    chk("stall new latency", 32'(cnt), 32'd1);
    chk("stall new flags", 32'(flags(1)), 32'b010);
    @(negedge clk);
    chk("stall new done", 32'({out_valid[1], in_ready[1]}), 32'b01);

    // Reset during the second compare cycle discards the transaction
    @(negedge clk);
    in_a[1] = 8'h01; in_b[1] = 8'h02; in_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("mid reset busy before", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid reset immediate",
        32'({out_valid[1], flags(1), busy[1], in_ready[1]}), 32'b0_000_0_1);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid[1] || busy[1]) cnt++;
    end
    chk("mid reset no result", 32'(cnt), 32'd0);

    // Check the discarded transaction left the block usable
    run_vec('{1, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 4, "post_reset_01_02"});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/serial_magnitude_compare_ctrl.md
Name: serial_magnitude_compare_ctrl

Overview:
- Sequencing controller that compares two WIDTH-bit unsigned operands with a single 2-bit compare slice.
- Walks the operands one 2-bit digit per cycle, MSB digit first.
- Stops at the first unequal digit when early exit is enabled.
- Valid/ready handshake on both the operand side and the result side; one transaction in flight at a time.

Parameters:
- WIDTH, 8: operand width in bits. Must be even and ≥2. DIGITS = WIDTH/2.
- EARLY_EXIT, 1: 1 = finish on the first unequal digit; 0 = always examine all DIGITS digits (constant latency).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- a_greater  output  1  A > B.
- b_greater  output  1  B > A.
- equal  output  1  A == B.
- busy  output  1  high in COMPARE or DONE.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; operand registers=0; digit index=DIGITS-1.
  - a_greater=b_greater=equal=0; out_valid=0; busy=0; in_ready=1.
  - Reset asserted mid-COMPARE or mid-DONE discards the transaction; no result is ever presented for it.
- States: IDLE, COMPARE, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid && in_ready at an edge: register in_a/in_b, index=DIGITS-1, clear the sticky result, go COMPARE.
  - in_a/in_b are don't-care outside the accepting edge.
- COMPARE, one digit per cycle. Digit d = bits [2d+1:2d]; unsigned 2-bit compare of A digit vs B digit.
  - Digit unequal and no earlier inequality recorded: record a_greater or b_greater.
  - EARLY_EXIT=1 and digit unequal: go DONE.
  - Else if index==0: go DONE; if nothing recorded, set equal.
  - Else: index decrements.
  - Only the first (most significant) inequality is recorded; later digits never overwrite it.
- Latency: the accepting edge is E0. After n compare cycles, out_valid is high following edge En.
  - n = number of digits examined, 1..DIGITS.
  - EARLY_EXIT=0: n = DIGITS always.
- DONE:
  - out_valid=1. Flags are exactly one-hot and held stable until out_valid && out_ready.
  - On that edge: flags clear to 0, go IDLE.
  - in_ready=0 throughout; in_valid is ignored.
  - No same-cycle result-to-accept overlap: the next operand is accepted at the earliest one cycle after the result handshake.
- Outside DONE, all three flags are 0.
- WIDTH=2: a single compare cycle, regardless of EARLY_EXIT.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1, A=0xB4, B=0xB4, out_ready=1 -> equal=1, other flags 0; out_valid high 4 cycles after accept, for exactly 1 cycle.
2. A=0x80, B=0x7F -> a_greater=1 after 1 compare cycle (top digit 2 vs 1); in_ready returns 1 the cycle after the result handshake.
3. A=0x12, B=0x13 -> b_greater=1 after 4 compare cycles (digits 3..1 equal, digit 0 is 2 vs 3).
4. After scenario 2's result is up, hold out_ready=0 for 5 cycles while driving in_valid=1 with A=0x00, B=0xFF -> flags and out_valid stable, in_ready=0, new operands not captured. Then raise out_ready -> IDLE; the new pair is accepted next cycle and yields b_greater.
5. Assert rst for 1 cycle during the 2nd COMPARE cycle of A=0x01, B=0x02 -> out_valid=0, flags 0, busy=0, in_ready=1 immediately; no result emitted after release.
6. EARLY_EXIT=0, A=0xC0, B=0x3F, then back-to-back A=0x3F, B=0xC0 -> a_greater at 4 cycles, then b_greater at 4 cycles; the later digits, which favour the other operand, never override the first inequality.
